// File: rtl/fc_weight_sequencer.sv
// Per-image weight/bias scheduler for the Layer-4 FC stage: captures the leading
// bias words, then packs the 16-bit weight stream four at a time into 64-bit beats.
module fc_weight_sequencer #(
    parameter int BIAS_NUM = 10,
    parameter int W_BEATS  = 320
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   start,
    input  logic [15:0]            fc_weight_TDATA,
    input  logic                   fc_weight_TVALID,
    output logic                   fc_weight_TREADY,
    output logic [63:0]            w_Data_TDATA,
    output logic                   w_Data_TVALID,
    input  logic                   w_Data_TREADY,
    output logic [16*BIAS_NUM-1:0] Bias_Data,
    output logic                   bias_valid,
    input  logic                   label_fire,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             fsm_state
);

    localparam int WORDS = 4 * W_BEATS;
    localparam int WCW   = $clog2(WORDS + 1);
    localparam int BCW   = $clog2(W_BEATS + 1);
    localparam int ICW   = $clog2(BIAS_NUM + 1);

    typedef enum logic [1:0] {IDLE, LOAD_BIAS, STREAM, WAIT_LABEL} state_t;

    state_t         state, next_state;
    logic [WCW-1:0] word_cnt;
    logic [BCW-1:0] beat_cnt;
    logic [ICW-1:0] bias_cnt;
    logic [1:0]     pack_cnt;
    logic [47:0]    pack;
    logic           word_fire, beat_fire, reload, bias_last, beat_last;

    // Both streams transfer on a rising edge where VALID and READY are high;
    // a producer holds VALID and DATA steady until that edge.
    always_comb begin
        fc_weight_TREADY = 1'b0;
        case (state)
            LOAD_BIAS: fc_weight_TREADY = 1'b1;
            STREAM:    fc_weight_TREADY = (word_cnt < WCW'(WORDS)) &&
                                          (pack_cnt != 2'd3 || !w_Data_TVALID || w_Data_TREADY);
            default:   fc_weight_TREADY = 1'b0;
        endcase
    end

    assign word_fire = fc_weight_TVALID && fc_weight_TREADY;
    assign beat_fire = (state == STREAM) && w_Data_TVALID && w_Data_TREADY;
    assign reload    = word_fire && (state == STREAM) && (pack_cnt == 2'd3);
    assign bias_last = word_fire && (state == LOAD_BIAS) && (bias_cnt == ICW'(BIAS_NUM - 1));
    assign beat_last = beat_fire && (beat_cnt == BCW'(W_BEATS - 1));
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (start)      next_state = LOAD_BIAS;
            LOAD_BIAS:  if (bias_last)  next_state = STREAM;
            STREAM:     if (beat_last)  next_state = WAIT_LABEL;
            WAIT_LABEL: if (label_fire) next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            word_cnt      <= '0;
            beat_cnt      <= '0;
            bias_cnt      <= '0;
            pack_cnt      <= '0;
            pack          <= '0;
            w_Data_TDATA  <= '0;
            w_Data_TVALID <= 1'b0;
            Bias_Data     <= '0;
            bias_valid    <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_cnt   <= '0;
                        beat_cnt   <= '0;
                        bias_cnt   <= '0;
                        pack_cnt   <= '0;
                        bias_valid <= 1'b0;
                    end
                end
                LOAD_BIAS: begin
                    if (word_fire) begin
                        for (int k = 0; k < BIAS_NUM; k++) begin
                            if (bias_cnt == ICW'(k)) Bias_Data[16*k +: 16] <= fc_weight_TDATA;
                        end
                        bias_cnt <= bias_cnt + ICW'(1);
                        if (bias_last) bias_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (word_fire) begin
                        word_cnt <= word_cnt + WCW'(1);
                        pack_cnt <= pack_cnt + 2'd1;
                        case (pack_cnt)
                            2'd0:    pack[15:0]   <= fc_weight_TDATA;
                            2'd1:    pack[31:16]  <= fc_weight_TDATA;
                            2'd2:    pack[47:32]  <= fc_weight_TDATA;
                            default: w_Data_TDATA <= {fc_weight_TDATA, pack};
                        endcase
                    end
                    // A reload in the handshake cycle keeps the beat slot full.
                    if (reload)         w_Data_TVALID <= 1'b1;
                    else if (beat_fire) w_Data_TVALID <= 1'b0;
                    if (beat_fire) beat_cnt <= beat_cnt + BCW'(1);
                end
                WAIT_LABEL: begin
                    w_Data_TVALID <= 1'b0;
                    if (label_fire) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
